// File: rtl/ikaopm_dac_rx.sv
// OPM serial sound-data receiver: frames the SO stream with SH1/SH2 and decodes
// each 13-bit floating-point word into a signed 16-bit PCM sample per channel.
module ikaopm_dac_rx #(
    parameter int unsigned FRAME_LEN     = 32,
    parameter bit          ZERO_EXP_HOLD = 1'b0
) (
    input  logic        i_EMUCLK,
    input  logic        i_MRST,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_SO,
    input  logic        i_SH1,
    input  logic        i_SH2,
    input  logic        i_ERR_CLR,
    output logic [15:0] o_CH1_PCM,
    output logic [15:0] o_CH2_PCM,
    output logic        o_CH1_VLD,
    output logic        o_CH2_VLD,
    output logic        o_FMT_ERR,
    output logic        o_SYNC_ERR
);

    localparam logic [5:0] FRAME_LEN_C = 6'(FRAME_LEN);

    logic        bit_en;
    logic [1:0]  sh_in;
    logic [1:0]  fall;
    logic [15:0] window;
    logic        fmt_set;
    logic        sync_set;

    logic [15:0] w_q, w_d;
    logic [1:0]  sh_z_q, sh_z_d;
    logic [1:0]  first_q, first_d;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  vld_q, vld_d;
    logic [5:0]  cnt_q [2];
    logic [5:0]  cnt_d [2];
    logic [12:0] frm_q [2];
    logic [12:0] frm_d [2];
    logic [15:0] pcm_q [2];
    logic [15:0] pcm_d [2];
    logic        fmt_q, fmt_d;
    logic        sync_q, sync_d;

    assign bit_en = ~i_phi1_NCEN_n;
    assign sh_in  = {i_SH2, i_SH1};
    // The window includes the bit sampled on the same enable as the fall.
    assign window = {i_SO, w_q[15:1]};

    function automatic logic [15:0] decode(input logic [12:0] f, input logic [15:0] prev);
        logic [15:0] m;
        logic [2:0]  e;
        e = f[12:10];
        m = {{6{~f[9]}}, ~f[9], f[8:0]};
        if (e == 3'd0) begin
            decode = ZERO_EXP_HOLD ? prev : '0;
        end else begin
            decode = m << (e - 3'd1);
        end
    endfunction

    always_comb begin
        w_d      = w_q;
        sh_z_d   = sh_z_q;
        first_d  = first_q;
        pend_d   = '0;
        vld_d    = '0;
        cnt_d    = cnt_q;
        frm_d    = frm_q;
        pcm_d    = pcm_q;
        fall     = '0;
        fmt_set  = 1'b0;
        sync_set = 1'b0;

        if (bit_en) begin
            w_d = window;
        end

        for (int unsigned ch = 0; ch < 2; ch++) begin
            fall[ch]   = bit_en & sh_z_q[ch] & ~sh_in[ch];
            vld_d[ch]  = pend_q[ch];
            pend_d[ch] = fall[ch];

            if (pend_q[ch]) begin
                pcm_d[ch] = decode(frm_q[ch], pcm_q[ch]);
                if (frm_q[ch][12:10] == 3'd0) begin
                    fmt_set = 1'b1;
                end
            end

            if (bit_en) begin
                sh_z_d[ch] = sh_in[ch];
                if (fall[ch]) begin
                    // The fall enable is slot 1 of the following period.
                    frm_d[ch]   = window[12:0];
                    cnt_d[ch]   = 6'd1;
                    first_d[ch] = 1'b1;
                    if (first_q[ch] && (cnt_q[ch] != FRAME_LEN_C)) begin
                        sync_set = 1'b1;
                    end
                end else if (cnt_q[ch] != '1) begin
                    cnt_d[ch] = cnt_q[ch] + 6'd1;
                end
            end
        end

        fmt_d  = (fmt_q & ~i_ERR_CLR) | fmt_set;
        sync_d = (sync_q & ~i_ERR_CLR) | sync_set;
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            w_q     <= '0;
            sh_z_q  <= '0;
            first_q <= '0;
            pend_q  <= '0;
            vld_q   <= '0;
            cnt_q   <= '{default: '0};
            frm_q   <= '{default: '0};
            pcm_q   <= '{default: '0};
            fmt_q   <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            w_q     <= w_d;
            sh_z_q  <= sh_z_d;
            first_q <= first_d;
            pend_q  <= pend_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            frm_q   <= frm_d;
            pcm_q   <= pcm_d;
            fmt_q   <= fmt_d;
            sync_q  <= sync_d;
        end
    end

    assign o_CH1_PCM  = pcm_q[0];
    assign o_CH2_PCM  = pcm_q[1];
    assign o_CH1_VLD  = vld_q[0];
    assign o_CH2_VLD  = vld_q[1];
    assign o_FMT_ERR  = fmt_q;
    assign o_SYNC_ERR = sync_q;

endmodule

// File: tb/tb_ikaopm_dac_rx.sv
// Bench for ikaopm_dac_rx: directed and random frames on both channels, with
// a zero-exponent-zeroing instance and a zero-exponent-holding instance in parallel.
module tb_ikaopm_dac_rx;

    logic clk = 1'b0;
    logic mrst, ncen, so, sh1, sh2, err_clr;

    logic [15:0] a_pcm1, a_pcm2, b_pcm1, b_pcm2;
    logic        a_vld1, a_vld2, b_vld1, b_vld2;
    logic        a_fmt, a_sync, b_fmt, b_sync;

    int errors = 0;
    int checks = 0;

    int          cnt_m  [2];
    bit          had_m  [2];
    logic [15:0] exp_pcm [2][2];
    bit          exp_fmt;
    bit          exp_sync;

    always #5 clk = ~clk;

    ikaopm_dac_rx #(.FRAME_LEN(32), .ZERO_EXP_HOLD(1'b0)) dut_a (
        .i_EMUCLK(clk), .i_MRST(mrst), .i_phi1_NCEN_n(ncen), .i_SO(so),
        .i_SH1(sh1), .i_SH2(sh2), .i_ERR_CLR(err_clr),
        .o_CH1_PCM(a_pcm1), .o_CH2_PCM(a_pcm2), .o_CH1_VLD(a_vld1), .o_CH2_VLD(a_vld2),
        .o_FMT_ERR(a_fmt), .o_SYNC_ERR(a_sync)
    );

    ikaopm_dac_rx #(.FRAME_LEN(32), .ZERO_EXP_HOLD(1'b1)) dut_b (
        .i_EMUCLK(clk), .i_MRST(mrst), .i_phi1_NCEN_n(ncen), .i_SO(so),
        .i_SH1(sh1), .i_SH2(sh2), .i_ERR_CLR(err_clr),
        .o_CH1_PCM(b_pcm1), .o_CH2_PCM(b_pcm2), .o_CH1_VLD(b_vld1), .o_CH2_VLD(b_vld2),
        .o_FMT_ERR(b_fmt), .o_SYNC_ERR(b_sync)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value of the word as a number: signed 10-bit mantissa times 2^(E-1).
    function automatic logic [15:0] model_pcm(input logic [15:0] f, input logic [15:0] prev,
                                              input bit hold);
        int e, mag, val;
        e   = int'(f[12:10]);
        mag = int'(f[8:0]);
        val = f[9] ? mag : mag - 512;
        if (e == 0) return hold ? prev : 16'h0000;
        return 16'(val * (1 << (e - 1)));
    endfunction

    function automatic logic [15:0] mk(input logic [9:0] m, input logic [2:0] e);
        logic [2:0] pad;
        pad = 3'($urandom_range(0, 7));
        return {pad, e, m};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            cnt_m[c] = 0;
            had_m[c] = 1'b0;
            exp_pcm[0][c] = '0;
            exp_pcm[1][c] = '0;
        end
        exp_fmt  = 1'b0;
        exp_sync = 1'b0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_a_pcm1"}, 32'(a_pcm1), 32'(exp_pcm[0][0]));
        chk({tag, "_a_pcm2"}, 32'(a_pcm2), 32'(exp_pcm[0][1]));
        chk({tag, "_b_pcm1"}, 32'(b_pcm1), 32'(exp_pcm[1][0]));
        chk({tag, "_b_pcm2"}, 32'(b_pcm2), 32'(exp_pcm[1][1]));
        chk({tag, "_errs"}, 32'({a_fmt, b_fmt, a_sync, b_sync}),
            32'({exp_fmt, exp_fmt, exp_sync, exp_sync}));
    endtask

    // mode 0: plain frame; 1: ERR_CLR on the decode cycle; 2: reset on the decode cycle
    task automatic frame(input bit f1, input bit f2, input logic [15:0] word,
                         input int plen, input int mode);
        bit fl [2];
        bit last;
        bit fmt_ev;
        fl[0] = f1;
        fl[1] = f2;
        for (int i = 0; i < plen; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                ncen = 1'b1;
            end
            @(negedge clk);
            last = (i == plen - 1);
            ncen = 1'b0;
            so   = (i >= plen - 16) ? word[i - (plen - 16)] : 1'($urandom_range(0, 1));
            sh1  = !(last && f1);
            sh2  = !(last && f2);
            for (int c = 0; c < 2; c++) begin
                cnt_m[c]++;
                if (last && fl[c]) begin
                    if (had_m[c] && cnt_m[c] != 32) exp_sync = 1'b1;
                    had_m[c] = 1'b1;
                    cnt_m[c] = 0;
                end
            end
        end
        @(negedge clk);
        ncen = 1'b1;
        chk("vld_early", 32'({a_vld1, a_vld2, b_vld1, b_vld2}), 32'h0);
        if (mode == 2) begin
            mrst = 1'b1;
            @(negedge clk);
            mrst = 1'b0;
            model_reset();
            chk("rst_vld", 32'({a_vld1, a_vld2, b_vld1, b_vld2}), 32'h0);
            chk_outputs("rst");
        end else begin
            err_clr = (mode == 1);
            fmt_ev  = 1'b0;
            for (int c = 0; c < 2; c++) begin
                if (fl[c]) begin
                    if (word[12:10] == 3'd0) fmt_ev = 1'b1;
                    exp_pcm[0][c] = model_pcm(word, exp_pcm[0][c], 1'b0);
                    exp_pcm[1][c] = model_pcm(word, exp_pcm[1][c], 1'b1);
                end
            end
            if (mode == 1) begin
                exp_fmt  = fmt_ev;
                exp_sync = 1'b0;
            end else begin
                exp_fmt = exp_fmt | fmt_ev;
            end
            @(negedge clk);
            err_clr = 1'b0;
            chk("vld_pulse", 32'({a_vld1, a_vld2, b_vld1, b_vld2}), 32'({f1, f2, f1, f2}));
            chk_outputs("dec");
            @(negedge clk);
            chk("vld_end", 32'({a_vld1, a_vld2, b_vld1, b_vld2}), 32'h0);
        end
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr  = 1'b0;
        exp_fmt  = 1'b0;
        exp_sync = 1'b0;
        chk("clr_errs", 32'({a_fmt, b_fmt, a_sync, b_sync}), 32'h0);
    endtask

    initial begin
        bit any_vld;
        bit rf1, rf2;
        int plen, mode;
        mrst = 1'b1; ncen = 1'b1; so = 1'b0; sh1 = 1'b1; sh2 = 1'b1; err_clr = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            ncen = 1'b0;
            so   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("reset_vld", 32'({a_vld1, a_vld2, b_vld1, b_vld2}), 32'h0);
        chk_outputs("reset");
        mrst = 1'b0;
        ncen = 1'b1;

        // Small positive value, then periods 32, 32, 31 on SH1
        frame(1'b1, 1'b0, mk(10'h201, 3'd1), 40, 0);
        chk("t1_pcm", 32'(a_pcm1), 32'h0001);
        frame(1'b1, 1'b0, mk(10'h155, 3'd2), 32, 0);
        frame(1'b1, 1'b0, mk(10'h0F0, 3'd4), 32, 0);
        chk("t5_sync_low", 32'(a_sync), 32'h0);
        frame(1'b1, 1'b0, mk(10'h300, 3'd6), 31, 0);
        chk("t5_sync_high", 32'(a_sync), 32'h1);
        clear_errs();

        // Full-scale extremes on SH2
        frame(1'b0, 1'b1, mk(10'h3FF, 3'd7), 32, 0);
        chk("t2_max", 32'(a_pcm2), 32'h7FC0);
        frame(1'b0, 1'b1, mk(10'h000, 3'd7), 32, 0);
        chk("t2_min", 32'(a_pcm2), 32'h8000);

        // Simultaneous falls, each channel decodes the shared word
        frame(1'b1, 1'b1, mk(10'h1FF, 3'd3), 32, 0);
        chk("t3_neg4", 32'({a_pcm1, a_pcm2}), 32'hFFFCFFFC);
        clear_errs();
        frame(1'b1, 1'b1, mk(10'h2AB, 3'd5), 32, 0);
        chk("t3_0ab0", 32'({a_pcm1, a_pcm2}), 32'h0AB00AB0);

        // Zero exponent: zero vs hold, sticky format error, set beats clear
        frame(1'b1, 1'b0, mk(10'h3C5, 3'd0), 32, 0);
        chk("t4_zero", 32'({a_pcm1, b_pcm1, 15'h0, a_fmt}), 32'h00000AB0 << 16 | 32'h1);
        clear_errs();
        frame(1'b0, 1'b1, mk(10'h011, 3'd0), 32, 1);
        clear_errs();

        for (int n = 0; n < 40; n++) begin
            rf1 = 1'($urandom_range(0, 1));
            rf2 = 1'($urandom_range(0, 1));
            if (!rf1 && !rf2) rf1 = 1'b1;
            plen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(28, 36)) : 32;
            mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            frame(rf1, rf2, mk(10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7))),
                  plen, mode);
            if (n % 10 == 9) clear_errs();
        end

        // Reset on the decode cycle discards the pending sample
        frame(1'b1, 1'b1, mk(10'h3FF, 3'd7), 32, 2);

        // Strobes held low through reset release produce no fall
        @(negedge clk);
        sh1 = 1'b0; sh2 = 1'b0; mrst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ncen = 1'b0;
            so   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        mrst    = 1'b0;
        any_vld = 1'b0;
        repeat (20) begin
            @(negedge clk);
            ncen    = 1'b0;
            so      = 1'($urandom_range(0, 1));
            any_vld = any_vld | a_vld1 | a_vld2 | b_vld1 | b_vld2;
        end
        @(negedge clk);
        ncen    = 1'b1;
        any_vld = any_vld | a_vld1 | a_vld2 | b_vld1 | b_vld2;
        chk("held_low_no_vld", 32'(any_vld), 32'h0);
        chk_outputs("held_low");
        frame(1'b1, 1'b0, mk(10'h2AB, 3'd5), 32, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
